// File: rtl/bus_capture.sv
// rtl/bus_capture.sv - VIC-II data-bus capture: character line buffer, g-access latch, sprite pointer/bitmap assembly
module bus_capture #(
    parameter int NUM_SPRITES  = 8,
    parameter int LINE_CHARS   = 40,
    parameter int CHAR_W       = 12,
    parameter int SPRITE_BYTES = 3,
    parameter int SPR_IDX_W    = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1
) (
    input  logic                                clk_dot4x,
    input  logic                                rst,
    input  logic                                vic_write_db,
    input  logic                                phi_phase_start_dav,
    input  logic [3:0]                          cycle_type,
    input  logic [CHAR_W-1:0]                   dbi,
    input  logic                                idle,
    input  logic                                line_start,
    input  logic [SPR_IDX_W-1:0]                sprite_cnt,
    input  logic [NUM_SPRITES-1:0]              sprite_dma,
    output logic [CHAR_W-1:0]                   char_next,
    output logic [CHAR_W-1:0]                   char_read,
    output logic [7:0]                          pixels_read,
    output logic [NUM_SPRITES*8-1:0]            sprite_ptr,
    output logic [NUM_SPRITES*8*SPRITE_BYTES-1:0] sprite_pixels,
    output logic [NUM_SPRITES-1:0]              sprite_done,
    output logic                                char_overflow
);
    localparam logic [3:0] VIC_LP  = 4'd0;
    localparam logic [3:0] VIC_LS2 = 4'd2;
    localparam logic [3:0] VIC_LG  = 4'd4;
    localparam logic [3:0] VIC_HS1 = 4'd5;
    localparam logic [3:0] VIC_HS3 = 4'd8;
    localparam logic [3:0] VIC_HRC = 4'd10;
    localparam logic [3:0] VIC_HGC = 4'd11;
    localparam logic [3:0] VIC_HGI = 4'd12;
    localparam logic [3:0] VIC_HRX = 4'd15;

    localparam int CPTR_W = (LINE_CHARS > 1) ? $clog2(LINE_CHARS) : 1;
    localparam int CNT_W  = 3;
    localparam int SW     = 8 * SPRITE_BYTES;

    logic [CHAR_W-1:0] char_buf [LINE_CHARS];
    logic [CPTR_W-1:0] cptr;
    logic              line_full;
    logic [7:0]        spr_ptr  [NUM_SPRITES];
    logic [SW-1:0]     spr_pix  [NUM_SPRITES];
    logic [CNT_W-1:0]  spr_cnt  [NUM_SPRITES];

    logic                 cap, is_char, is_idle, is_spr_s, spr_ok, cptr_wrap, cnt_last;
    logic [SPR_IDX_W-1:0] spr_sel;
    logic [SW+7:0]        shift_cat;

    always_comb begin
        cap       = phi_phase_start_dav && !vic_write_db;
        is_char   = (cycle_type == VIC_HRC) || (cycle_type == VIC_HGC);
        is_idle   = (cycle_type == VIC_HRX) || (cycle_type == VIC_HGI);
        is_spr_s  = (cycle_type == VIC_HS1) || (cycle_type == VIC_LS2) || (cycle_type == VIC_HS3);
        spr_ok    = int'(sprite_cnt) < NUM_SPRITES;
        spr_sel   = spr_ok ? sprite_cnt : '0;
        cptr_wrap = (cptr == CPTR_W'(LINE_CHARS - 1));
        cnt_last  = (spr_cnt[spr_sel] == CNT_W'(SPRITE_BYTES - 1));
        shift_cat = {spr_pix[spr_sel], dbi[7:0]};
    end

    // line_full marks that the pointer has already wrapped this line; a further advance is an overflow
    always_ff @(posedge clk_dot4x or posedge rst) begin
        if (rst) begin
            char_next     <= '0;
            char_read     <= '0;
            pixels_read   <= '0;
            sprite_done   <= '0;
            char_overflow <= 1'b0;
            line_full     <= 1'b0;
            cptr          <= '0;
            for (int i = 0; i < LINE_CHARS; i++) char_buf[i] <= CHAR_W'('hff);
            for (int n = 0; n < NUM_SPRITES; n++) begin
                spr_ptr[n] <= 8'hff;
                spr_pix[n] <= '0;
                spr_cnt[n] <= '0;
            end
        end else begin
            sprite_done <= '0;
            if (cap) begin
                if (is_char || is_idle) begin
                    char_next <= is_char ? dbi : char_buf[cptr];
                    if (is_char) char_buf[cptr] <= dbi;
                    cptr <= cptr_wrap ? '0 : CPTR_W'(cptr + 1'b1);
                    if (cptr_wrap) line_full <= 1'b1;
                    if (line_full) char_overflow <= 1'b1;
                end
                if (cycle_type == VIC_LG) begin
                    pixels_read <= dbi[7:0];
                    char_read   <= idle ? '0 : char_next;
                end else begin
                    pixels_read <= '0;
                end
                if (spr_ok && cycle_type == VIC_LP)
                    spr_ptr[spr_sel] <= sprite_dma[spr_sel] ? dbi[7:0] : 8'hff;
                if (spr_ok && is_spr_s && sprite_dma[spr_sel]) begin
                    spr_pix[spr_sel] <= shift_cat[SW-1:0];
                    if (cnt_last) begin
                        spr_cnt[spr_sel]     <= '0;
                        sprite_done[spr_sel] <= 1'b1;
                    end else begin
                        spr_cnt[spr_sel] <= CNT_W'(spr_cnt[spr_sel] + 1'b1);
                    end
                end
            end
            if (line_start) begin
                cptr          <= '0;
                char_overflow <= 1'b0;
                line_full     <= 1'b0;
                for (int n = 0; n < NUM_SPRITES; n++) spr_cnt[n] <= '0;
            end
        end
    end

    for (genvar n = 0; n < NUM_SPRITES; n++) begin : g_flat
        assign sprite_ptr[8*n +: 8]     = spr_ptr[n];
        assign sprite_pixels[SW*n +: SW] = spr_pix[n];
    end
endmodule

// File: tb/tb_bus_capture.sv
// tb/tb_bus_capture.sv - directed and randomized bench for bus_capture against a line-level reference model
module tb_bus_capture;
    localparam int NS = 8;
    localparam int LC = 40;
    localparam int SB = 3;

    localparam logic [3:0] VIC_LP = 4'd0, VIC_LS2 = 4'd2, VIC_LG = 4'd4, VIC_HS1 = 4'd5;
    localparam logic [3:0] VIC_HS3 = 4'd8, VIC_HRC = 4'd10, VIC_HGC = 4'd11, VIC_HGI = 4'd12, VIC_HRX = 4'd15;

    logic              clk_dot4x = 1'b0;
    logic              rst = 1'b1;
    logic              vic_write_db = 1'b0;
    logic              phi_phase_start_dav = 1'b0;
    logic [3:0]        cycle_type = 4'd0;
    logic [11:0]       dbi = '0;
    logic              idle = 1'b0;
    logic              line_start = 1'b0;
    logic [2:0]        sprite_cnt = '0;
    logic [NS-1:0]     sprite_dma = '0;
    logic [11:0]       char_next, char_read;
    logic [7:0]        pixels_read;
    logic [NS*8-1:0]   sprite_ptr;
    logic [NS*24-1:0]  sprite_pixels;
    logic [NS-1:0]     sprite_done;
    logic              char_overflow;

    bus_capture #(.NUM_SPRITES(NS), .LINE_CHARS(LC), .CHAR_W(12), .SPRITE_BYTES(SB)) dut (
        .clk_dot4x(clk_dot4x), .rst(rst), .vic_write_db(vic_write_db),
        .phi_phase_start_dav(phi_phase_start_dav), .cycle_type(cycle_type), .dbi(dbi),
        .idle(idle), .line_start(line_start), .sprite_cnt(sprite_cnt), .sprite_dma(sprite_dma),
        .char_next(char_next), .char_read(char_read), .pixels_read(pixels_read),
        .sprite_ptr(sprite_ptr), .sprite_pixels(sprite_pixels), .sprite_done(sprite_done),
        .char_overflow(char_overflow)
    );

    always #5 clk_dot4x = ~clk_dot4x;

    int n_checks = 0;
    int n_err = 0;

    // Reference state: buffer position is simply the number of char advances this line modulo LC
    logic [11:0] m_buf [LC];
    int          m_acc;
    logic [11:0] m_cn, m_cr;
    logic [7:0]  m_pix;
    logic [7:0]  m_ptr [NS];
    logic [23:0] m_spx [NS];
    int          m_sb  [NS];
    logic [NS-1:0] m_done;

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < LC; i++) m_buf[i] = 12'h0ff;
        m_acc = 0; m_cn = '0; m_cr = '0; m_pix = '0; m_done = '0;
        for (int n = 0; n < NS; n++) begin m_ptr[n] = 8'hff; m_spx[n] = '0; m_sb[n] = 0; end
    endtask

    task automatic model_step();
        logic [11:0] old_cn;
        int s;
        old_cn = m_cn;
        s = int'(sprite_cnt);
        m_done = '0;
        if (phi_phase_start_dav && !vic_write_db) begin
            if (cycle_type inside {VIC_HRC, VIC_HGC}) begin
                m_cn = dbi; m_buf[m_acc % LC] = dbi; m_acc++;
            end else if (cycle_type inside {VIC_HRX, VIC_HGI}) begin
                m_cn = m_buf[m_acc % LC]; m_acc++;
            end
            if (cycle_type == VIC_LG) begin
                m_pix = dbi[7:0]; m_cr = idle ? 12'h0 : old_cn;
            end else m_pix = 8'h00;
            if (s < NS && cycle_type == VIC_LP) m_ptr[s] = sprite_dma[s] ? dbi[7:0] : 8'hff;
            if (s < NS && cycle_type inside {VIC_HS1, VIC_LS2, VIC_HS3} && sprite_dma[s]) begin
                m_spx[s] = {m_spx[s][15:0], dbi[7:0]};
                m_sb[s]++;
                if (m_sb[s] == SB) begin m_sb[s] = 0; m_done[s] = 1'b1; end
            end
        end
        if (line_start) begin
            m_acc = 0;
            for (int n = 0; n < NS; n++) m_sb[n] = 0;
        end
    endtask

    task automatic check_all(input string ctx);
        logic [NS*8-1:0]  ep;
        logic [NS*24-1:0] ex;
        for (int n = 0; n < NS; n++) begin ep[8*n +: 8] = m_ptr[n]; ex[24*n +: 24] = m_spx[n]; end
        chk({ctx, ".char_next"}, char_next, m_cn);
        chk({ctx, ".char_read"}, char_read, m_cr);
        chk({ctx, ".pixels_read"}, pixels_read, m_pix);
        chk({ctx, ".sprite_ptr"}, sprite_ptr, ep);
        chk({ctx, ".sprite_pixels"}, sprite_pixels, ex);
        chk({ctx, ".sprite_done"}, sprite_done, m_done);
        chk({ctx, ".char_overflow"}, char_overflow, m_acc > LC);
    endtask

    task automatic step(input string ctx, input logic [3:0] ct, input logic [11:0] d,
                        input logic dav, input logic wr, input logic ls);
        cycle_type = ct; dbi = d; phi_phase_start_dav = dav; vic_write_db = wr; line_start = ls;
        @(posedge clk_dot4x); #1;
        model_step();
        check_all(ctx);
        phi_phase_start_dav = 1'b0; line_start = 1'b0; vic_write_db = 1'b0;
    endtask

    logic [11:0] last_d;

    initial begin
        model_reset();
        repeat (3) @(posedge clk_dot4x);
        #1 rst = 1'b0;
        check_all("reset");

        // Badline: 40 c-accesses
        step("ls", VIC_HRC, 12'h0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < LC; i++) step("badline", VIC_HRC, 12'(i), 1'b1, 1'b0, 1'b0);
        chk("badline_last", char_next, 12'd39);
        chk("badline_no_ovf", char_overflow, 1'b0);

        // Idle line re-reads the buffered characters
        step("ls", VIC_HRX, 12'h0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < LC; i++) begin
            step("idleline", VIC_HRX, 12'h0, 1'b1, 1'b0, 1'b0);
            chk("idle_seq", char_next, 12'(i));
        end

        // Overflow on the 41st c-access
        step("ls", VIC_HRC, 12'h0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < LC; i++) step("ovf", VIC_HRC, 12'($urandom), 1'b1, 1'b0, 1'b0);
        chk("ovf_at_40", char_overflow, 1'b0);
        last_d = 12'($urandom);
        step("ovf41", VIC_HRC, last_d, 1'b1, 1'b0, 1'b0);
        chk("ovf_at_41", char_overflow, 1'b1);
        step("ovf_clr", VIC_HRC, 12'h0, 1'b0, 1'b0, 1'b1);
        chk("ovf_cleared", char_overflow, 1'b0);
        step("entry0", VIC_HRX, 12'h0, 1'b1, 1'b0, 1'b0);
        chk("entry0_overwritten", char_next, last_d);

        // g-access
        step("ls", VIC_HRC, 12'h0, 1'b0, 1'b0, 1'b1);
        step("g_c", VIC_HRC, 12'h123, 1'b1, 1'b0, 1'b0);
        idle = 1'b0;
        step("g0", VIC_LG, 12'h0a5, 1'b1, 1'b0, 1'b0);
        chk("g_pixels", pixels_read, 8'ha5);
        chk("g_char", char_read, 12'h123);
        idle = 1'b1;
        step("g1", VIC_LG, 12'h0a5, 1'b1, 1'b0, 1'b0);
        chk("g_idle_char", char_read, 12'h000);
        idle = 1'b0;
        step("g_after", VIC_HRX, 12'h0, 1'b1, 1'b0, 1'b0);
        chk("g_pix_cleared", pixels_read, 8'h00);

        // Sprite 3 fetch with DMA, then sprite 4 without
        step("ls", VIC_LP, 12'h0, 1'b0, 1'b0, 1'b1);
        sprite_dma = 8'h08; sprite_cnt = 3'd3;
        step("sp3_p", VIC_LP, 12'h080, 1'b1, 1'b0, 1'b0);
        step("sp3_s1", VIC_HS1, 12'h011, 1'b1, 1'b0, 1'b0);
        chk("sp3_no_early_done", sprite_done, 8'h00);
        step("sp3_s2", VIC_LS2, 12'h022, 1'b1, 1'b0, 1'b0);
        step("sp3_s3", VIC_HS3, 12'h033, 1'b1, 1'b0, 1'b0);
        chk("sp3_ptr", sprite_ptr[31:24], 8'h80);
        chk("sp3_pixels", sprite_pixels[95:72], 24'h112233);
        chk("sp3_done", sprite_done, 8'h08);
        step("sp3_idle", VIC_HRX, 12'h0, 1'b0, 1'b0, 1'b0);
        chk("sp3_done_one_clk", sprite_done, 8'h00);
        sprite_cnt = 3'd4;
        step("sp4_p", VIC_LP, 12'h080, 1'b1, 1'b0, 1'b0);
        step("sp4_s1", VIC_HS1, 12'h011, 1'b1, 1'b0, 1'b0);
        step("sp4_s2", VIC_LS2, 12'h022, 1'b1, 1'b0, 1'b0);
        step("sp4_s3", VIC_HS3, 12'h033, 1'b1, 1'b0, 1'b0);
        chk("sp4_ptr", sprite_ptr[39:32], 8'hff);
        chk("sp4_pixels", sprite_pixels[119:96], 24'h0);
        chk("sp4_no_done", sprite_done, 8'h00);

        // Inhibit: VIC driving the bus blocks every access type
        sprite_dma = 8'hff;
        for (int t = 0; t < 16; t++) begin
            sprite_cnt = 3'($urandom);
            step("inhibit", 4'(t), 12'($urandom), 1'b1, 1'b1, 1'b0);
        end

        // Randomized traffic
        for (int k = 0; k < 600; k++) begin
            idle = 1'($urandom);
            sprite_cnt = 3'($urandom);
            sprite_dma = 8'($urandom);
            step("rand", 4'($urandom_range(0, 15)), 12'($urandom),
                 $urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0, $urandom_range(0, 50) == 0);
        end

        // Asynchronous reset mid-line, then capture resumes at pointer 0
        #2 rst = 1'b1;
        #1;
        model_reset();
        check_all("midreset");
        @(posedge clk_dot4x); #1 rst = 1'b0;
        step("post_rst", VIC_HRX, 12'h0, 1'b1, 1'b0, 1'b0);
        chk("post_rst_buf", char_next, 12'h0ff);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
